muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative 32-bit multiply/divide controller for the EX stage of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the decoder and sequences a shared shift/add-subtract datapath over 32 iterations. It owns the HI/LO registers and services MFHI/MFLO/MTHI/MTLO. Its `busy` output feeds the hazard unit, which stalls the pipeline.

## Interface
- `WIDTH`, 32, operand/HI/LO width
- `ITERS`, 32, iteration count (must equal `WIDTH`)
- `Clk`  in  1  rising-edge clock
- `Rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  issue pulse, qualified with `op`
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op
- `opA`  in  32  rs value (multiplicand/dividend/MT source)
- `opB`  in  32  rt value (multiplier/divisor)
- `busy`  out  1  operation in flight; pipeline must stall
- `done`  out  1  one-cycle pulse, HI/LO updated
- `divByZero`  out  1  pulse with `done` for DIV/DIVU when `opB`=0
- `hiOut`  out  32  HI register (MFHI source)
- `loOut`  out  32  LO register (MFLO source)

## Operation
- States: IDLE, BUSY, FIXUP, DONE.
- **IDLE**
  - `start` with op 0–3: latch operand magnitudes (signed ops take the two's-complement absolute value; unsigned ops pass through), latch the result sign, counter := 31, go to BUSY.
  - `start` with op 4/5: write HI/LO from `opA` this edge; stay in IDLE; no `done`.
  - `start` with op 6/7: ignored.
- **BUSY**: one iteration per cycle; counter decrements; exits to FIXUP after the iteration at counter=0.
  - Multiply: shift-add on a 64-bit {acc, multiplier} pair.
  - Divide: restoring shift-subtract on a 64-bit {rem, quotient} pair.
- **FIXUP** (1 cycle): apply signs, then write HI/LO.
  - MULT: negate the 64-bit product if sign(A)^sign(B).
  - DIV: negate the quotient if sign(A)^sign(B); the remainder takes the sign of the dividend.
  - Result mapping: MUL HI=product[63:32], LO=product[31:0]; DIV LO=quotient, HI=remainder.
- **DONE** (1 cycle): `done`=1, then IDLE.
- Divide by zero: LO=32'hFFFFFFFF, HI=`opA` (original, unsigned view), `divByZero`=1 with `done`. The FSM still runs the full sequence, so latency is constant.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude arithmetic; no special case.
- `start` while `busy`=1: ignored entirely (no op, operand or HI/LO change).
- HI/LO change only at the FIXUP edge, on an MT write, or at reset.

## Timing
- Reset (async, `Rst_n`=0): state IDLE, counter 0, HI=LO=0, `busy`=0, `done`=0, `divByZero`=0. Reset mid-operation aborts with no HI/LO write.
- Start accepted at edge E0.
- `busy`=1 from the cycle after E0 through the FIXUP cycle: 33 cycles. `busy` is registered and derived from state (BUSY or FIXUP).
- HI/LO valid after edge E0+33.
- `done` high during cycle E0+34 (after edge E0+33, before E0+34).
- Back-to-back: the earliest next accepted start is the edge ending the DONE cycle.
- MT write: `hiOut`/`loOut` reflect the new value the cycle after the `start` edge.
- `hiOut`/`loOut` are direct register outputs with no combinational path from inputs.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings (`OP_MULT`…`OP_MTLO`)
  - state encoding (2 bits)
  - `WIDTH`, `ITERS`
- Sub-module `muldiv_datapath`:
  - holds the 64-bit work register, the adder/subtractor and the sign-fixup negators
  - controlled by `load`, `step`, `isDiv`, `fixup` strobes from the FSM in `muldiv_sequencer`
- HI/LO registers and the iteration counter stay in the top module.

## Test plan
- MULT opA=0xFFFFFFFD (−3), opB=5 → after 34 cycles `done`; HI=0xFFFFFFFF, LO=0xFFFFFFF1; `busy` high exactly 33 cycles.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 → LO=14, HI=2.
- DIVU 100/0 → LO=0xFFFFFFFF, HI=0x64, `divByZero`=1 coincident with `done`.
- Overflow and busy rejection:
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - A second `start` (MTHI 0x1234) during BUSY → ignored, HI holds the divide result.
- Reset and MT writes:
  - MTLO 0xA5A5A5A5 → `loOut` updates next cycle.
  - Start MULT, then `Rst_n`=0 at iteration 10 → HI=LO=0, `busy`=0 immediately; no `done` after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    // Two's-complement magnitude for signed operands; unsigned operands pass through.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return neg_w(v);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift/add-subtract datapath: 64-bit work register, adder/subtractor, sign fixup.
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             isDiv,
    input  logic             fixup,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] work_r;
    logic [WIDTH-1:0]   opnd_r;
    logic               neg_res_r;
    logic               neg_rem_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH+1:0]   trial_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;

    // Multiply keeps the multiplier in the low half and shifts product bits in from the top;
    // divide shifts the dividend out of the low half while quotient bits fill in behind it.
    assign sum_s      = {1'b0, work_r[2*WIDTH-1:WIDTH]} + (work_r[0] ? {1'b0, opnd_r} : (WIDTH+1)'(0));
    assign mul_next_s = {sum_s, work_r[WIDTH-1:1]};
    assign trial_s    = {1'b0, work_r[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_r};
    assign div_next_s = trial_s[WIDTH+1] ? {work_r[2*WIDTH-2:0], 1'b0}
                                         : {trial_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
    assign prod_fix_s = neg_res_r ? neg_2w(work_r) : work_r;

    // Operand load and per-cycle iteration of the work register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            work_r    <= (2*WIDTH)'(0);
            opnd_r    <= WIDTH'(0);
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
        end else if (load) begin
            work_r    <= {WIDTH'(0), isDiv ? magnitude(a, is_signed) : magnitude(b, is_signed)};
            opnd_r    <= isDiv ? magnitude(b, is_signed) : magnitude(a, is_signed);
            neg_res_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_r <= is_signed & a[WIDTH-1];
        end else if (step) begin
            work_r    <= isDiv ? div_next_s : mul_next_s;
        end else begin
            work_r    <= work_r;
        end
    end

    // Signed results are produced only while the FSM sits in its fixup cycle.
    always_comb begin
        hi = work_r[2*WIDTH-1:WIDTH];
        lo = work_r[WIDTH-1:0];
        if (fixup) begin
            if (isDiv) begin
                hi = neg_rem_r ? neg_w(work_r[2*WIDTH-1:WIDTH]) : work_r[2*WIDTH-1:WIDTH];
                lo = neg_res_r ? neg_w(work_r[WIDTH-1:0]) : work_r[WIDTH-1:0];
            end else begin
                hi = prod_fix_s[2*WIDTH-1:WIDTH];
                lo = prod_fix_s[WIDTH-1:0];
            end
        end else begin
            hi = work_r[2*WIDTH-1:WIDTH];
            lo = work_r[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide controller: FSM, iteration counter and the architectural HI/LO registers.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    state_e           state_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic             div_r;
    logic             bzero_r;

    logic             accept_s;
    logic             load_s;
    logic             step_s;
    logic             fixup_s;
    logic             div_sel_s;
    logic [WIDTH-1:0] dp_hi_s;
    logic [WIDTH-1:0] dp_lo_s;

    // DONE accepts a new start so back-to-back issue costs no extra cycle.
    assign accept_s  = start && (state_r == ST_IDLE || state_r == ST_DONE);
    assign load_s    = accept_s && !op[2];
    assign step_s    = (state_r == ST_BUSY);
    assign fixup_s   = (state_r == ST_FIXUP);
    assign div_sel_s = load_s ? op[1] : div_r;

    muldiv_datapath u_datapath (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .load      (load_s),
        .step      (step_s),
        .isDiv     (div_sel_s),
        .fixup     (fixup_s),
        .is_signed (!op[0]),
        .a         (opA),
        .b         (opB),
        .hi        (dp_hi_s),
        .lo        (dp_lo_s)
    );

    // Sequencing FSM with registered status outputs and HI/LO ownership.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            count_r <= CNT_W'(0);
            hi_r    <= WIDTH'(0);
            lo_r    <= WIDTH'(0);
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
            div_r   <= 1'b0;
            bzero_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    state_r <= ST_IDLE;
                    if (accept_s) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_r <= ST_BUSY;
                                busy_r  <= 1'b1;
                                count_r <= CNT_W'(ITERS - 1);
                                div_r   <= op[1];
                                bzero_r <= (opB == WIDTH'(0));
                            end
                            OP_MTHI: hi_r <= opA;
                            OP_MTLO: lo_r <= opA;
                            default: state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (count_r == CNT_W'(0)) begin
                        state_r <= ST_FIXUP;
                    end else begin
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                ST_FIXUP: begin
                    // A zero divisor leaves the dividend as the remainder; only LO needs forcing.
                    hi_r    <= dp_hi_s;
                    lo_r    <= (div_r && bzero_r) ? {WIDTH{1'b1}} : dp_lo_s;
                    dbz_r   <= div_r && bzero_r;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign divByZero = dbz_r;
    assign hiOut     = hi_r;
    assign loOut     = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: random and directed ops against an arithmetic model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic        busy, done, divByZero;
    logic [31:0] hiOut, loOut;

    muldiv_sequencer dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .divByZero(divByZero), .hiOut(hiOut), .loOut(loOut)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    int          passed = 0;
    int          total  = 0;
    int          busy_run = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] pr;
        longint      q, r;
        e = '0;
        case (o)
            OP_MULT: begin
                pr = longint'($signed(a)) * longint'($signed(b));
                e.hi = pr[63:32]; e.lo = pr[31:0];
            end
            OP_MULTU: begin
                pr = {32'd0, a} * {32'd0, b};
                e.hi = pr[63:32]; e.lo = pr[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
                end else if (o == OP_DIV) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done and measures each busy window.
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                check("busy_len", 64'(busy_run), 64'd33);
                busy_run = 0;
            end
            if (done) begin
                if (sb_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else begin
                    e = sb_q.pop_front();
                    check("hi", 64'(hiOut), 64'(e.hi));
                    check("lo", 64'(loOut), 64'(e.lo));
                    check("div_by_zero", 64'(divByZero), 64'(e.dbz));
                end
            end
        end
    end

    task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; opA = a; opB = b;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input bit inject);
        exp_t e;
        int   cycles;
        e = model(o, a, b);
        sb_q.push_back(e);
        pulse(o, a, b);
        cycles = 1;
        while (!done && cycles < 60) begin
            if (inject && cycles == 5) begin
                start = 1'b1; op = OP_MTHI; opA = 32'h0000_1234;
            end else begin
                start = 1'b0;
            end
            @(negedge Clk);
            cycles++;
        end
        start = 1'b0;
        check("latency", 64'(cycles), 64'd34);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        pulse(o, a, $urandom);
        if (o == OP_MTHI) m_hi = a;
        else if (o == OP_MTLO) m_lo = a;
        check("mt_hi", 64'(hiOut), 64'(m_hi));
        check("mt_lo", 64'(loOut), 64'(m_lo));
        check("mt_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        bit          seen;

        repeat (3) @(negedge Clk);
        check("rst_hi", 64'(hiOut), 64'd0);
        check("rst_lo", 64'(loOut), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(divByZero), 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        run_arith(OP_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0);
        run_arith(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_arith(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        run_arith(OP_DIVU,  32'd100, 32'd7, 1'b0);
        run_arith(OP_DIVU,  32'd100, 32'd0, 1'b0);
        run_arith(OP_DIV,   32'hFFFF_FFF9, 32'd0, 1'b0);
        run_arith(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("rejected_mthi", 64'(hiOut), 64'd0);
        mt(OP_MTLO, 32'hA5A5_A5A5);
        mt(OP_MTHI, 32'h5A5A_0001);
        mt(3'd6, 32'h1111_1111);
        mt(3'd7, 32'h2222_2222);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 50)) - 32'd25;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20)) - 32'd10;
            if (o <= OP_DIVU) run_arith(o, a, b, 1'b0);
            else mt(o, a);
        end

        // Abort a multiply mid-flight: reset must clear HI/LO and no done may follow.
        pulse(OP_MULT, 32'd12345, 32'd678);
        repeat (9) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("abort_hi", 64'(hiOut), 64'd0);
        check("abort_lo", 64'(loOut), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge Clk);
        #2 Rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_hi_hold", 64'(hiOut), 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
